if_stage: RTL
=============

# if_stage

Instruction fetch stage of the rv32 3-stage pipeline. Owns the program counter and drives the word address into the combinational instruction ROM (`imem`). Captures the returned instruction word with its PC into a 2-entry fetch buffer, then hands pairs to decode over a valid/ready handshake. Handles redirects from execute (branch/jump) by flushing the buffer and reloading the PC.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `ADDR_W`, default 10: width of the `imem` word address.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_addr`  out  ADDR_W  word address to `imem`; always `fetch_pc[ADDR_W+1:2]`.
- `imem_data`  in  32  instruction word from `imem`; combinational, valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  32  target PC for the redirect.
- `id_valid`  out  1  buffer head holds a valid instruction.
- `id_ready`  in  1  decode accepts the head this cycle.
- `id_pc`  out  32  PC of the head entry.
- `id_instr`  out  32  instruction word of the head entry.
- `id_misalign`  out  1  head entry came from a misaligned redirect; see Configuration.

## Operation

State:
- `fetch_pc[31:0]`
- 2-entry circular buffer of {pc, instr, misalign}
- 1-bit read and write pointers
- `count[1:0]`, range 0..2

Per-cycle events:
- **pop** = `id_valid & id_ready & ~redirect_valid`
- **push** = `~redirect_valid & ~halt & (count < 2 | pop)`
- On push: entry written with {`fetch_pc`, `imem_data`, 0}; `fetch_pc <= fetch_pc + 4`, modulo 2^32.
- When push is not allowed: `fetch_pc` and `imem_addr` hold.
- **Redirect**: `count <= 0`, pointers <= 0, `fetch_pc <= redirect_pc` (alignment per Configuration). Any handshake in the same cycle is discarded: no pop is counted and no push occurs.
- Push and pop together: `count` unchanged. Full with a simultaneous pop is a legal push.
- Head outputs:
  - `id_valid = (count != 0)`.
  - `id_pc`, `id_instr`, `id_misalign` come from the read-pointer entry; stale contents are visible while `id_valid` = 0.
- `imem_addr` wraps at 2^ADDR_W words: 4 KiB at the default `ADDR_W`. `fetch_pc` keeps the full 32 bits.
- `halt` is always 0 unless the Configuration feature is enabled.

## Timing

- Reset values:
  - `fetch_pc` = `RESET_PC`; `count` = 0; pointers = 0.
  - All buffer entries = 0, so `id_pc` = 0, `id_instr` = 0, `id_misalign` = 0.
  - `id_valid` = 0; `imem_addr` = `RESET_PC[ADDR_W+1:2]`; `halt` = 0.
- `rst` has priority over `redirect_valid` and over the handshake.
- Fetch-to-decode latency is 1 cycle: a word pushed at edge N is visible with `id_valid` = 1 in cycle N+1.
- Redirect asserted in cycle t:
  - Cycle t+1: `id_valid` = 0, `imem_addr` = target word.
  - Cycle t+2: `id_valid` = 1 with `id_pc` = target.
- Throughput is 1 instruction/cycle while `id_ready` is held high.
- Backpressure: with `id_ready` low, 2 entries fill, then `fetch_pc` stalls; no instruction is dropped or duplicated.

## Configuration

Macro: `IF_MISALIGN_TRAP_EN`.

Defined:
- A redirect with `redirect_pc[1:0] != 0` loads `fetch_pc` unaligned and sets `halt`.
- The next push writes one entry {`redirect_pc`, 32'h0, misalign=1}. Fetch then stops pushing until the next redirect or reset, which clears `halt`.
- `id_misalign` reflects the head entry.

Undefined:
- `redirect_pc[1:0]` is forced to 2'b00.
- `halt` and `id_misalign` are constant 0.

## Test plan

- Reset release, `id_ready` = 1, ROM words 0..5 = 00000533, 00250513, 40a505b3, 40a58633, 40a606b3, 40a68733 -> `id_valid` rises 1 cycle after reset; `id_pc` = 0,4,8,... on consecutive cycles with matching words; word 6 onward reads 0.
- `id_ready` = 0 for 5 cycles after reset -> `count` saturates at 2, `imem_addr` holds at 2, `id_pc` stays 0; on `id_ready` = 1, PCs 0,4,8 are delivered in order with none lost.
- Redirect to 0x10 while full and with `id_ready` = 1 -> no pop that cycle; next cycle `id_valid` = 0; the cycle after, `id_pc` = 0x10, `id_instr` = 40a606b3.
- `rst` and `redirect_valid` asserted together -> `fetch_pc` = `RESET_PC`; buffer empty.
- `RESET_PC` = 0xFFC, `ADDR_W` = 10 -> `imem_addr` goes 1023 then 0; `id_pc` goes 0xFFC then 0x1000.
- With `IF_MISALIGN_TRAP_EN`, redirect to 0x6 -> a single entry with `id_pc` = 6, `id_instr` = 0, `id_misalign` = 1, then `id_valid` = 0 until a redirect to 0x0 resumes fetch at 00000533. Without the macro, the same redirect fetches from 0x4 (00250513) with `id_misalign` = 0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage -- instruction fetch stage of the rv32 3-stage pipeline.
//
// Owns the fetch PC and drives the word address into a combinational
// instruction ROM. Each returned word is captured with its PC in a 2-entry
// circular buffer. The buffer head is offered to decode over valid/ready.
// A redirect from execute flushes the buffer and reloads the PC.
//
// Build option: define IF_MISALIGN_TRAP_EN to trap misaligned redirects.
// A misaligned target produces a single buffer entry {pc, 32'h0, misalign=1}.
// Fetch then halts until the next redirect or reset. Without the macro,
// redirect targets are forced word-aligned and id_misalign is always 0.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   synchronous active-high reset
//   imem_addr      out  [ADDR_W-1:0] word address = fetch_pc[ADDR_W+1:2]
//   imem_data      in   [31:0] instruction word (same-cycle, combinational)
//   redirect_valid in   execute requests a PC change
//   redirect_pc    in   [31:0] redirect target
//   id_valid       out  buffer head is valid
//   id_ready       in   decode accepts head
//   id_pc          out  [31:0] PC of head entry
//   id_instr       out  [31:0] instruction of head entry
//   id_misalign    out  head entry came from a misaligned redirect
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_pc,
  output logic [31:0]       id_instr,
  output logic              id_misalign
);

  logic [31:0] fetch_pc;
  logic [31:0] buf_pc    [2];
  logic [31:0] buf_instr [2];
  logic        buf_mis   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  // trap_pend: a misaligned redirect was taken and its marker entry is not yet
  // written. halt: marker written, fetch stopped until redirect/reset.
  logic        halt;
  logic        trap_pend;

  logic        pop;
  logic        push;
  logic [31:0] push_instr;
  logic        push_mis;
  logic [31:0] redir_target;
  logic        redir_mis;

  always_comb begin
    pop        = id_valid & id_ready & ~redirect_valid;
    push       = ~redirect_valid & ~halt & ((count != 2'd2) | pop);
    push_instr = trap_pend ? 32'h0 : imem_data;
    push_mis   = trap_pend;
`ifdef IF_MISALIGN_TRAP_EN
    redir_target = redirect_pc;
    redir_mis    = (redirect_pc[1:0] != 2'b00);
`else
    redir_target = redirect_pc & ~32'h3;
    redir_mis    = 1'b0;
`endif
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      halt      <= 1'b0;
      trap_pend <= 1'b0;
    end else if (redirect_valid) begin
      halt      <= 1'b0;
      trap_pend <= redir_mis;
    end else if (push && trap_pend) begin
      halt      <= 1'b1;
      trap_pend <= 1'b0;
    end
  end
`else
  assign halt      = 1'b0;
  assign trap_pend = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= 32'h0;
        buf_instr[i] <= 32'h0;
        buf_mis[i]   <= 1'b0;
      end
    end else if (redirect_valid) begin
      // Entries are left stale; only the occupancy is cleared.
      fetch_pc <= redir_target;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]    <= fetch_pc;
        buf_instr[wr_ptr] <= push_instr;
        buf_mis[wr_ptr]   <= push_mis;
        wr_ptr            <= ~wr_ptr;
        // The trap marker does not advance the PC; fetch halts after it.
        if (!trap_pend)
          fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign imem_addr   = fetch_pc[ADDR_W+1:2];
  assign id_valid    = (count != 2'd0);
  assign id_pc       = buf_pc[rd_ptr];
  assign id_instr    = buf_instr[rd_ptr];
  assign id_misalign = buf_mis[rd_ptr];

endmodule
